// File: rtl/spi_master_txn_ctrl.sv
// rtl/spi_master_txn_ctrl.sv - SPI mode-0 transaction sequencer running CMD, ADDR, DUMMY and DATA phases
// Define SPI_MASTER_TXN_CTRL_ABORT_EN to add the abort/aborted ports.
module spi_master_txn_ctrl #(
   parameter int DIV_W   = 8,
   parameter int LEN_W   = 6,
   parameter int DUMMY_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIV_W-1:0]   clk_div,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_rd,
   input  logic [31:0]        req_cmd,
   input  logic [LEN_W-1:0]   req_cmd_len,
   input  logic [31:0]        req_addr,
   input  logic [LEN_W-1:0]   req_addr_len,
   input  logic [DUMMY_W-1:0] req_dummy_len,
   input  logic [LEN_W-1:0]   req_data_len,
   input  logic [31:0]        req_wdata,
   output logic [31:0]        rdata,
   output logic               done,
   output logic               busy,
   output logic               spi_sck,
   output logic               spi_csn,
   output logic               spi_mosi,
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
   input  logic               abort,
   output logic               aborted,
`endif
   input  logic               spi_miso
);
   localparam int CNT_W = (DUMMY_W > 6) ? DUMMY_W : 6;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

   state_t             state_q, state_d, nxt;
   logic               enter;
   logic [DIV_W-1:0]   div_q, div_d, tick_q, tick_d;
   logic [CNT_W-1:0]   bits_q, bits_d;
   logic [31:0]        sh_q, sh_d, cmd_q, cmd_d, addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [5:0]         cmd_len_q, cmd_len_d, addr_len_q, addr_len_d, data_len_q, data_len_d;
   logic [DUMMY_W-1:0] dummy_q, dummy_d;
   logic               rd_q, rd_d, sck_q, sck_d, csn_q, csn_d;
   logic               done_q, done_d, busy_q, busy_d, ready_q, ready_d;
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
   logic               aborted_q, aborted_d;
`endif

   function automatic logic [5:0] clamp_len(input logic [LEN_W-1:0] len);
      if (32'(len) > 32'd32) return 6'd32;
      return 6'(len);
   endfunction

   // Later checks override earlier ones, so the earliest non-empty phase after 'from' wins.
   function automatic state_t next_phase(input state_t from, input logic [5:0] cl,
                                         input logic [5:0] al, input logic [5:0] dl,
                                         input logic [DUMMY_W-1:0] dm);
      state_t n;
      n = S_DONE;
      if (dl != '0 && from < S_DATA)  n = S_DATA;
      if (dm != '0 && from < S_DUMMY) n = S_DUMMY;
      if (al != '0 && from < S_ADDR)  n = S_ADDR;
      if (cl != '0 && from < S_CMD)   n = S_CMD;
      return n;
   endfunction

   function automatic logic [31:0] align_msb(input logic [31:0] v, input logic [5:0] len);
      return v << (6'd32 - len);
   endfunction

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      tick_d     = tick_q;
      bits_d     = bits_q;
      sh_d       = sh_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      cmd_len_d  = cmd_len_q;
      addr_len_d = addr_len_q;
      data_len_d = data_len_q;
      dummy_d    = dummy_q;
      rd_d       = rd_q;
      sck_d      = sck_q;
      csn_d      = csn_q;
      done_d     = 1'b0;
      nxt        = S_DONE;
      enter      = 1'b0;
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
      aborted_d  = aborted_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               div_d      = clk_div;
               cmd_d      = req_cmd;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               cmd_len_d  = clamp_len(req_cmd_len);
               addr_len_d = clamp_len(req_addr_len);
               data_len_d = clamp_len(req_data_len);
               dummy_d    = req_dummy_len;
               rd_d       = req_rd;
               rdata_d    = '0;
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
               aborted_d  = 1'b0;
`endif
               nxt   = next_phase(S_IDLE, cmd_len_d, addr_len_d, data_len_d, dummy_d);
               enter = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            if (tick_q == div_q) begin
               tick_d = '0;
               sck_d  = ~sck_q;
               if (!sck_q) begin
                  if (state_q == S_DATA && rd_q) rdata_d = {rdata_q[30:0], spi_miso};
               end else if (bits_q == CNT_W'(1)) begin
                  nxt   = next_phase(state_q, cmd_len_d, addr_len_d, data_len_d, dummy_d);
                  enter = 1'b1;
               end else begin
                  bits_d = bits_q - CNT_W'(1);
                  sh_d   = {sh_q[30:0], 1'b0};
               end
            end else begin
               tick_d = tick_q + DIV_W'(1);
            end
         end
      endcase
      if (enter) begin
         state_d = nxt;
         tick_d  = '0;
         sck_d   = 1'b0;
         csn_d   = (nxt == S_DONE);
         done_d  = (nxt == S_DONE);
         case (nxt)
            S_CMD: begin
               sh_d   = align_msb(cmd_d, cmd_len_d);
               bits_d = CNT_W'(cmd_len_d);
            end
            S_ADDR: begin
               sh_d   = align_msb(addr_d, addr_len_d);
               bits_d = CNT_W'(addr_len_d);
            end
            S_DUMMY: begin
               sh_d   = '0;
               bits_d = CNT_W'(dummy_d);
            end
            S_DATA: begin
               sh_d   = rd_d ? 32'd0 : align_msb(wdata_d, data_len_d);
               bits_d = CNT_W'(data_len_d);
            end
            default: begin
               sh_d   = '0;
               bits_d = '0;
            end
         endcase
      end
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
      if (abort && state_q != S_IDLE && state_q != S_DONE) begin
         state_d   = S_IDLE;
         sck_d     = 1'b0;
         csn_d     = 1'b1;
         sh_d      = '0;
         done_d    = 1'b1;
         aborted_d = 1'b1;
      end
`endif
      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         tick_q     <= '0;
         bits_q     <= '0;
         sh_q       <= '0;
         cmd_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cmd_len_q  <= '0;
         addr_len_q <= '0;
         data_len_q <= '0;
         dummy_q    <= '0;
         rd_q       <= 1'b0;
         sck_q      <= 1'b0;
         csn_q      <= 1'b1;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
         aborted_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
         bits_q     <= bits_d;
         sh_q       <= sh_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         cmd_len_q  <= cmd_len_d;
         addr_len_q <= addr_len_d;
         data_len_q <= data_len_d;
         dummy_q    <= dummy_d;
         rd_q       <= rd_d;
         sck_q      <= sck_d;
         csn_q      <= csn_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
         aborted_q  <= aborted_d;
`endif
      end
   end

   assign req_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign spi_sck   = sck_q;
   assign spi_csn   = csn_q;
   assign spi_mosi  = sh_q[31];
`ifdef SPI_MASTER_TXN_CTRL_ABORT_EN
   assign aborted   = aborted_q;
`endif

endmodule
